// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM with shared prescaler/period counter and double-buffered duties.
// Latency: out/period_start are registered, reflecting counter and duty state of the previous clk.
// Backpressure: none; duty writes are always accepted (writes to channels >= M are dropped).
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   en                  bank enable; while low the counter is parked and shadows are copied through
//   prescale            counter advances once every prescale+1 clk cycles
//   period              counter terminal value, sampled at period boundaries
//   wr_en/wr_ch/wr_duty shadow duty write port
//   in                  per-channel source bits, gated by the PWM compare
//   out                 registered PWM outputs
//   period_start        one-clk pulse in the first cycle of each new period
//
// Optional build: define PWM_BANK_CENTER_ALIGNED_EN for an up/down (centre-aligned) counter.

module pwm_bank #(
    parameter int N    = 8,
    parameter int M    = 4,
    parameter int CH_W = 2,
    parameter int PS_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic [PS_W-1:0] prescale,
    input  logic [N-1:0]    period,
    input  logic            wr_en,
    input  logic [CH_W-1:0] wr_ch,
    input  logic [N-1:0]    wr_duty,
    input  logic [M-1:0]    in,
    output logic [M-1:0]    out,
    output logic            period_start
);

    logic [PS_W-1:0] ps;
    logic [N-1:0]    cnt;
    logic [N-1:0]    cnt_nxt;
    logic [N-1:0]    period_act;
    logic [N-1:0]    duty_sh  [M];
    logic [N-1:0]    duty_act [M];
    logic            tick;
    logic            boundary;

    // Equality (not >=) so a prescale lowered below the current ps lets ps wrap
    // through its full range before the next tick.
    assign tick = (ps == prescale);

`ifdef PWM_BANK_CENTER_ALIGNED_EN
    logic dir_down;
    logic dir_down_nxt;

    // Up 0..period_act, then down to 0. The boundary is the downward step into 0;
    // degenerate periods (0 or 1) reach 0 straight from the peak.
    always_comb begin
        cnt_nxt      = cnt;
        dir_down_nxt = dir_down;
        boundary     = 1'b0;
        if (tick) begin
            if (!dir_down) begin
                if (cnt >= period_act) begin
                    if (period_act <= N'(1)) begin
                        boundary = 1'b1;
                        cnt_nxt  = '0;
                    end else begin
                        dir_down_nxt = 1'b1;
                        cnt_nxt      = cnt - N'(1);
                    end
                end else begin
                    cnt_nxt = cnt + N'(1);
                end
            end else begin
                if (cnt <= N'(1)) begin
                    boundary     = 1'b1;
                    cnt_nxt      = '0;
                    dir_down_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - N'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_down <= 1'b0;
        end else if (!en) begin
            dir_down <= 1'b0;
        end else begin
            dir_down <= dir_down_nxt;
        end
    end
`else
    always_comb begin
        cnt_nxt  = cnt;
        boundary = 1'b0;
        if (tick) begin
            if (cnt == period_act) begin
                boundary = 1'b1;
                cnt_nxt  = '0;
            end else begin
                cnt_nxt = cnt + N'(1);
            end
        end
    end
`endif

    // Shadow duty registers. Only channels 0..M-1 are decoded, so a wr_ch >= M
    // matches nothing and the write is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < M; i++) begin
                duty_sh[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < M; i++) begin
                if (wr_ch == CH_W'(i)) begin
                    duty_sh[i] <= wr_duty;
                end
            end
        end
    end

    // Counter, active registers and outputs. A write landing on a boundary
    // cycle is not seen here: duty_act takes the pre-write shadow value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps           <= '0;
            cnt          <= '0;
            period_act   <= '1;
            out          <= '0;
            period_start <= 1'b0;
            for (int i = 0; i < M; i++) begin
                duty_act[i] <= '0;
            end
        end else if (!en) begin
            // Parked: keep active values tracking the inputs so the first
            // period after enable uses whatever was programmed meanwhile.
            ps           <= '0;
            cnt          <= '0;
            period_act   <= period;
            out          <= '0;
            period_start <= 1'b0;
            for (int i = 0; i < M; i++) begin
                duty_act[i] <= duty_sh[i];
            end
        end else begin
            ps           <= tick ? '0 : ps + PS_W'(1);
            cnt          <= cnt_nxt;
            period_start <= boundary;
            if (boundary) begin
                period_act <= period;
                for (int i = 0; i < M; i++) begin
                    duty_act[i] <= duty_sh[i];
                end
            end
            for (int i = 0; i < M; i++) begin
                out[i] <= in[i] & (cnt < duty_act[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: randomized + directed bench for pwm_bank with a scoreboard.
// A 3-bit channel select is used so that out-of-range writes (wr_ch >= M) can be driven.
// The reference model tracks prescaler phase and tick position within the period.

module tb_pwm_bank;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [3:0] prescale;
    logic [7:0] period;
    logic       wr_en;
    logic [2:0] wr_ch;
    logic [7:0] wr_duty;
    logic [3:0] in_v;
    logic [3:0] out_v;
    logic       pst;

    pwm_bank #(.N(8), .M(4), .CH_W(3), .PS_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .prescale     (prescale),
        .period       (period),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .in           (in_v),
        .out          (out_v),
        .period_start (pst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] sb[$];          // expected {out, period_start} per clk
    logic [3:0] last_out;
    logic       last_pst;
    int         meas_len;
    int         meas_hi[4];

    // Reference model state
    int m_ps;                   // clk cycles elapsed inside the current tick
    int m_pos;                  // ticks elapsed inside the current period
    int m_plen;                 // period in force for this period
    int m_dsh[4];
    int m_dact[4];

    task automatic model_reset();
        m_ps = 0; m_pos = 0; m_plen = 255;
        for (int i = 0; i < 4; i++) begin m_dsh[i] = 0; m_dact[i] = 0; end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clk: drive inputs, predict registered outputs, queue the prediction.
    task automatic cyc(input logic e, input logic [3:0] pre, input logic [7:0] per,
                       input logic we, input logic [2:0] wch, input logic [7:0] wd,
                       input logic [3:0] iv);
        logic [3:0] nout;
        logic       npst;
        logic       tk;
        en = e; prescale = pre; period = per;
        wr_en = we; wr_ch = wch; wr_duty = wd; in_v = iv;
        nout = '0; npst = 1'b0;
        if (!e) begin
            m_ps = 0; m_pos = 0; m_plen = int'(per);
            for (int i = 0; i < 4; i++) m_dact[i] = m_dsh[i];
        end else begin
            for (int i = 0; i < 4; i++) nout[i] = iv[i] && (m_pos < m_dact[i]);
            tk   = (m_ps == int'(pre));
            m_ps = tk ? 0 : (m_ps + 1) % 16;
            npst = tk && (m_pos == m_plen);
            if (npst) begin
                m_pos = 0; m_plen = int'(per);
                for (int i = 0; i < 4; i++) m_dact[i] = m_dsh[i];
            end else if (tk) begin
                m_pos++;
            end
        end
        if (we && wch < 3'd4) m_dsh[wch] = int'(wd);
        @(posedge clk);
        sb.push_back({nout, npst});
        #1;
        last_out = out_v;
        last_pst = pst;
    endtask

    // Measure one period window from a period_start pulse to the next, counting
    // per-channel high samples. Optionally write a duty at cycle offset 'off'.
    task automatic measure(input logic [3:0] pre, input logic [7:0] per, input int off,
                           input logic [2:0] wch, input logic [7:0] wd);
        int guard;
        int len;
        bit done;
        guard = 0;
        while (!last_pst && guard < 400) begin
            cyc(1'b1, pre, per, 1'b0, 3'd0, 8'd0, 4'hF);
            guard++;
        end
        if (!last_pst) begin
            n_tests++; n_fail++;
            $display("FAIL measure_start: no period_start within %0d clk", guard);
            meas_len = 0;
            return;
        end
        len = 1;
        for (int i = 0; i < 4; i++) meas_hi[i] = int'(last_out[i]);
        done = 1'b0;
        guard = 0;
        while (!done) begin
            cyc(1'b1, pre, per, (len - 1) == off, wch, wd, 4'hF);
            guard++;
            if (last_pst) begin
                done = 1'b1;
            end else if (guard > 400) begin
                n_tests++; n_fail++;
                $display("FAIL measure_end: period longer than %0d clk", guard);
                done = 1'b1;
            end else begin
                len++;
                for (int i = 0; i < 4; i++) meas_hi[i] += int'(last_out[i]);
            end
        end
        meas_len = len;
    endtask

    // Monitor: compares every registered output cycle against the model.
    initial begin
        logic [4:0] exp;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                n_tests++;
                if ({out_v, pst} !== exp) begin
                    n_fail++;
                    $display("FAIL sb: out=%b pst=%b expected out=%b pst=%b at %0t",
                             out_v, pst, exp[4:1], exp[0], $time);
                end
            end
        end
    end

    initial begin
        int n;
        reset_n = 1'b0; en = 1'b0; prescale = '0; period = '0;
        wr_en = 1'b0; wr_ch = '0; wr_duty = '0; in_v = '0;
        last_out = '0; last_pst = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_out", int'(out_v), 0);
        check("reset_pst", int'(pst), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Program shadows while disabled: ch0=5, ch1=0, ch2=12, ch3=3
        cyc(1'b0, 4'd0, 8'd9, 1'b1, 3'd0, 8'd5,  4'hF);
        cyc(1'b0, 4'd0, 8'd9, 1'b1, 3'd1, 8'd0,  4'hF);
        cyc(1'b0, 4'd0, 8'd9, 1'b1, 3'd2, 8'd12, 4'hF);
        cyc(1'b0, 4'd0, 8'd9, 1'b1, 3'd3, 8'd3,  4'hF);
        check("disabled_out", int'(last_out), 0);

        measure(4'd0, 8'd9, -1, 3'd0, 8'd0);
        check("p9_len", meas_len, 10);
        check("p9_ch0", meas_hi[0], 5);
        check("p9_ch1_duty0", meas_hi[1], 0);
        check("p9_ch2_duty12", meas_hi[2], 10);
        check("p9_ch3", meas_hi[3], 3);

        // Mid-period write: current window keeps 5, next shows 2
        measure(4'd0, 8'd9, 3, 3'd0, 8'd2);
        check("midwr_cur", meas_hi[0], 5);
        measure(4'd0, 8'd9, -1, 3'd0, 8'd0);
        check("midwr_next", meas_hi[0], 2);

        // Write on the boundary cycle (offset 9): applies one period later
        measure(4'd0, 8'd9, 9, 3'd0, 8'd7);
        check("bndwr_cur", meas_hi[0], 2);
        measure(4'd0, 8'd9, -1, 3'd0, 8'd0);
        check("bndwr_next", meas_hi[0], 2);
        measure(4'd0, 8'd9, 2, 3'd4, 8'd1);   // out-of-range channel
        check("bndwr_later", meas_hi[0], 7);
        measure(4'd0, 8'd9, -1, 3'd0, 8'd0);
        check("oor_ch0", meas_hi[0], 7);
        check("oor_ch1", meas_hi[1], 0);
        check("oor_ch2", meas_hi[2], 10);
        check("oor_ch3", meas_hi[3], 3);

        // prescale=3, period=4, ch0 duty 2
        cyc(1'b1, 4'd3, 8'd4, 1'b1, 3'd0, 8'd2, 4'hF);
        measure(4'd3, 8'd4, -1, 3'd0, 8'd0);
        measure(4'd3, 8'd4, -1, 3'd0, 8'd0);
        check("ps3_len", meas_len, 20);
        check("ps3_ch0", meas_hi[0], 8);
        check("ps3_ch2", meas_hi[2], 20);
        check("ps3_ch3", meas_hi[3], 12);

        // Disable mid-period: next cycle outputs are 0
        repeat (5) cyc(1'b1, 4'd3, 8'd4, 1'b0, 3'd0, 8'd0, 4'hF);
        check("pre_dis_ch2", int'(last_out[2]), 1);
        cyc(1'b0, 4'd3, 8'd4, 1'b0, 3'd0, 8'd0, 4'hF);
        check("dis_out", int'(last_out), 0);
        check("dis_pst", int'(last_pst), 0);
        repeat (2) cyc(1'b0, 4'd3, 8'd4, 1'b0, 3'd0, 8'd0, 4'hF);

        // Re-enable: restarts at cnt=0, first period_start after 20 clk
        n = 0;
        last_pst = 1'b0;
        while (!last_pst && n < 100) begin
            cyc(1'b1, 4'd3, 8'd4, 1'b0, 3'd0, 8'd0, 4'hF);
            n++;
        end
        check("reen_latency", n, 20);

        // Asynchronous reset mid-period
        repeat (3) cyc(1'b1, 4'd3, 8'd4, 1'b0, 3'd0, 8'd0, 4'hF);
        check("pre_rst_ch2", int'(last_out[2]), 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", int'(out_v), 0);
        check("async_rst_pst", int'(pst), 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        last_pst = 1'b0;

        // Randomized phase
        begin
            logic [3:0] rp;
            logic [7:0] rper;
            rp = 4'd1; rper = 8'd6;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(0, 49) == 0) rp = 4'($urandom_range(0, 3));
                if ($urandom_range(0, 39) == 0) rper = 8'($urandom_range(0, 15));
                cyc($urandom_range(0, 19) != 0, rp, rper,
                    $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                    8'($urandom_range(0, 17)), 4'($urandom_range(0, 15)));
            end
        end

        @(negedge clk);
        @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
